// File: rtl/axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile
//   AXI-lite slave register file.
//   - NUM_REGS registers, each DATA_W bits wide, are readable and writable
//     from the bus.
//   - Their contents are driven to fabric logic on regs_o.
//   - Registers flagged in RO_MASK are read-only: reads return the matching
//     status_i slice, and writes are refused with SLVERR.
//   - AW and W are each captured into a one-entry holding register, so they
//     may arrive in either order.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   awaddr/awvalid/awready                  write address channel
//   wdata/wstrb/wlast/wvalid/wready         write data channel (wlast ignored)
//   bresp/bvalid/bready                     write response (00 OKAY, 10 SLVERR)
//   araddr/arvalid/arready                  read address channel
//   rdata/rresp/rlast/rvalid/rready         read data channel (rlast = rvalid)
//   regs_o      register i at [i*DATA_W +: DATA_W]
//   status_i    values returned for read-only registers
//   wr_pulse_o  bit i high for one cycle after register i is written
//
// Configuration
//   AXI_LITE_REGFILE_STRB_EN  when defined, the wstrb port exists and only
//                             strobed bytes are written; otherwise every write
//                             updates the full word.
// ---------------------------------------------------------------------------
module axi_lite_regfile #(
    parameter int                   ADDR_W   = 32,
    parameter int                   DATA_W   = 32,
    parameter int                   NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
    parameter logic [DATA_W-1:0]    RST_VAL  = '0
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
`ifdef AXI_LITE_REGFILE_STRB_EN
    input  logic [DATA_W/8-1:0]          wstrb,
`endif
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    input  logic [NUM_REGS*DATA_W-1:0]   status_i,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    localparam int NBYTES = DATA_W / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(NUM_REGS);
    endfunction

    // An index that matches no register falls through as not writable.
    function automatic logic idx_writable(input logic [IDX_W-1:0] idx);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(idx) == 32'(i)) ok = !RO_MASK[i];
        end
        return ok;
    endfunction

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] ov,
                                                     input logic [DATA_W-1:0] nv,
                                                     input logic [NBYTES-1:0] strb);
        logic [DATA_W-1:0] res;
        for (int b = 0; b < NBYTES; b++) begin
            res[8*b +: 8] = strb[b] ? nv[8*b +: 8] : ov[8*b +: 8];
        end
        return res;
    endfunction

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_EXEC,
        WR_RESP
    } wr_state_t;

    wr_state_t             wr_state, wr_state_nxt;
    logic                  aw_held, w_held, aw_hs, w_hs, exec;
    logic                  aw_nxt, w_nxt, bvalid_nxt;
    logic [IDX_W-1:0]      aw_idx_h;
    logic [DATA_W-1:0]     w_data_h;
    logic [NBYTES-1:0]     w_strb_h, strb_in;
    logic                  wr_ok;
    logic [NUM_REGS-1:0]   wr_onehot;
    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_W-1:0]     rd_val;
    logic                  rd_err;
    logic                  ar_hs;
    logic                  unused_inputs;

`ifdef AXI_LITE_REGFILE_STRB_EN
    assign strb_in = wstrb;
`else
    assign strb_in = '1;
`endif

    // Only the index field of the addresses and part of status_i are consumed.
    assign unused_inputs = ^{wlast, awaddr, araddr, status_i};

    // Hold flags are decoded from the FSM state.
    // A pending response does not block new captures.
    assign aw_held = (wr_state == WR_HAVE_AW) || (wr_state == WR_EXEC);
    assign w_held  = (wr_state == WR_HAVE_W)  || (wr_state == WR_EXEC);
    assign awready = !aw_held;
    assign wready  = !w_held;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // Executing on the edge that retires the previous response keeps bvalid
    // high back-to-back.
    assign exec = (wr_state == WR_EXEC) && (!bvalid || bready);

    always_comb begin
        aw_nxt     = (aw_held && !exec) || aw_hs;
        w_nxt      = (w_held && !exec) || w_hs;
        bvalid_nxt = exec || (bvalid && !bready);
        if (aw_nxt && w_nxt)  wr_state_nxt = WR_EXEC;
        else if (aw_nxt)      wr_state_nxt = WR_HAVE_AW;
        else if (w_nxt)       wr_state_nxt = WR_HAVE_W;
        else if (bvalid_nxt)  wr_state_nxt = WR_RESP;
        else                  wr_state_nxt = WR_IDLE;
    end

    assign wr_ok = idx_writable(aw_idx_h);

    always_comb begin
        wr_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_onehot[i] = (32'(aw_idx_h) == 32'(i));
        end
    end

    // ---- capture stage: AW / W holding registers (data only, no reset) ----
    always_ff @(posedge aclk) begin
        if (aw_hs) aw_idx_h <= awaddr[LSB +: IDX_W];
        if (w_hs) begin
            w_data_h <= wdata;
            w_strb_h <= strb_in;
        end
    end

    // ---- execute stage: write FSM, response and pulse ----
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state   <= WR_IDLE;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
            wr_pulse_o <= '0;
        end else begin
            wr_state   <= wr_state_nxt;
            bvalid     <= bvalid_nxt;
            if (exec) bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            // The pulse fires even when every strobe is clear.
            wr_pulse_o <= (exec && wr_ok) ? wr_onehot : '0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
        end else if (exec && wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_onehot[i]) regs[i] <= byte_merge(regs[i], w_data_h, w_strb_h);
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_W +: DATA_W] = regs[g];
    end

    // ---- read stage: registered rdata/rresp ----
    assign rd_idx  = araddr[LSB +: IDX_W];
    assign arready = !rvalid;
    assign ar_hs   = arvalid && arready;
    assign rlast   = rvalid;

    always_comb begin
        rd_val = '0;
        rd_err = !idx_in_range(rd_idx);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_idx) == 32'(i)) begin
                rd_val = RO_MASK[i] ? status_i[i*DATA_W +: DATA_W] : regs[i];
            end
        end
    end

    // Sampling regs before the write's non-blocking update gives pre-write
    // data when a read and a write to the same register share an edge.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
            rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regfile
//   Scoreboard bench for axi_lite_regfile.
//   - Expected B and R responses are queued at issue time.
//   - A monitor pops the queues on each B or R handshake.
//   - A word-level array model holds the expected register contents.
// ---------------------------------------------------------------------------
module tb_axi_lite_regfile;

    localparam int                  ADDR_W   = 32;
    localparam int                  DATA_W   = 32;
    localparam int                  NUM_REGS = 12;
    localparam logic [NUM_REGS-1:0] RO_MASK  = 12'h001;
    localparam logic [DATA_W-1:0]   RST_VAL  = 32'h5A5A_0000;

    logic                       aclk, areset;
    logic [ADDR_W-1:0]          awaddr, araddr;
    logic                       awvalid, awready, wvalid, wready, wlast;
    logic [DATA_W-1:0]          wdata, rdata;
    logic [3:0]                 wstrb;
    logic [1:0]                 bresp, rresp;
    logic                       bvalid, bready, arvalid, arready;
    logic                       rlast, rvalid, rready;
    logic [NUM_REGS*DATA_W-1:0] regs_o, status;
    logic [NUM_REGS-1:0]        wr_pulse_o;
`ifndef AXI_LITE_REGFILE_STRB_EN
    logic                       tb_unused_sink;
    assign tb_unused_sink = ^wstrb;
`endif

    axi_lite_regfile #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS),
        .RO_MASK(RO_MASK), .RST_VAL(RST_VAL)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata),
`ifdef AXI_LITE_REGFILE_STRB_EN
        .wstrb(wstrb),
`endif
        .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .regs_o(regs_o), .status_i(status), .wr_pulse_o(wr_pulse_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct { logic [1:0] resp; logic [NUM_REGS-1:0] pulse; bit chk_pulse; } b_exp_t;
    typedef struct { logic [DATA_W-1:0] data; logic [1:0] resp; } r_exp_t;

    b_exp_t            bq[$];
    r_exp_t            rq[$];
    logic [DATA_W-1:0] mreg [NUM_REGS];
    int                n_checks = 0;
    int                n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_writable(input int idx);
        if (idx >= NUM_REGS) return 1'b0;
        return RO_MASK[idx] == 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] reg_o(input int i);
        return regs_o[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [ADDR_W-1:0] mk_addr(input int idx);
        return {26'($urandom), 4'(idx), 2'($urandom)};
    endfunction

    task automatic check_all_regs(input string name);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (m_writable(i)) check(name, 64'(reg_o(i)), 64'(mreg[i]));
        end
    endtask

    // Reference model: applies a write at word level and queues its response.
    task automatic m_write(input int idx, input logic [DATA_W-1:0] data,
                           input logic [3:0] strb, input bit chk_pulse);
        b_exp_t e;
        logic [3:0] eff;
`ifdef AXI_LITE_REGFILE_STRB_EN
        eff = strb;
`else
        eff = 4'hF;
`endif
        if (m_writable(idx)) begin
            for (int b = 0; b < 4; b++) if (eff[b]) mreg[idx][8*b +: 8] = data[8*b +: 8];
            e.resp  = 2'b00;
            e.pulse = NUM_REGS'(1) << idx;
        end else begin
            e.resp  = 2'b10;
            e.pulse = '0;
        end
        e.chk_pulse = chk_pulse;
        bq.push_back(e);
    endtask

    task automatic m_read(input int idx);
        r_exp_t e;
        if (idx >= NUM_REGS) begin
            e.data = '0;
            e.resp = 2'b10;
        end else begin
            e.data = RO_MASK[idx] ? status[idx*DATA_W +: DATA_W] : mreg[idx];
            e.resp = 2'b00;
        end
        rq.push_back(e);
    endtask

    task automatic send_aw(input logic [ADDR_W-1:0] a);
        int t = 0;
        awaddr = a; awvalid = 1'b1;
        @(negedge aclk);
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        check("aw_handshake", 64'(awready), 64'(1));
        @(posedge aclk); #1 awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DATA_W-1:0] d, input logic [3:0] s);
        int t = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        @(negedge aclk);
        while (!wready && t < 50) begin @(negedge aclk); t++; end
        check("w_handshake", 64'(wready), 64'(1));
        @(posedge aclk); #1 wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [ADDR_W-1:0] a);
        int t = 0;
        araddr = a; arvalid = 1'b1;
        @(negedge aclk);
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        check("ar_handshake", 64'(arready), 64'(1));
        @(posedge aclk); #1 arvalid = 1'b0;
    endtask

    task automatic do_write(input int idx, input logic [DATA_W-1:0] d,
                            input logic [3:0] s, input bit chk_pulse);
        logic [ADDR_W-1:0] a;
        a = mk_addr(idx);
        m_write(idx, d, s, chk_pulse);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic do_read(input int idx);
        m_read(idx);
        send_ar(mk_addr(idx));
    endtask

    task automatic drain();
        int t = 0;
        while ((bq.size() != 0 || rq.size() != 0) && t < 100) begin @(negedge aclk); t++; end
        check("drain", 64'(bq.size() + rq.size()), 64'(0));
        @(posedge aclk); #1;
    endtask

    // Monitor: pops expected responses on every B / R handshake.
    initial begin
        b_exp_t be;
        r_exp_t re;
        forever begin
            @(negedge aclk);
            if (!areset && bvalid && bready) begin
                check("b_expected", 64'(bq.size() != 0), 64'(1));
                if (bq.size() != 0) begin
                    be = bq.pop_front();
                    check("bresp", 64'(bresp), 64'(be.resp));
                    if (be.chk_pulse) check("wr_pulse", 64'(wr_pulse_o), 64'(be.pulse));
                end
            end
            if (!areset && rvalid && rready) begin
                check("r_expected", 64'(rq.size() != 0), 64'(1));
                if (rq.size() != 0) begin
                    re = rq.pop_front();
                    check("rdata", 64'(rdata), 64'(re.data));
                    check("rresp", 64'(rresp), 64'(re.resp));
                    check("rlast", 64'(rlast), 64'(1));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d5, d6, old6, old9, new9, wd;
        areset = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1; rready = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = 4'hF;
        for (int i = 0; i < NUM_REGS; i++) begin
            status[i*DATA_W +: DATA_W] = $urandom;
            mreg[i] = RST_VAL;
        end
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;

        // Reset state
        @(negedge aclk);
        check("rst_awready", 64'(awready), 64'(1));
        check("rst_wready",  64'(wready),  64'(1));
        check("rst_arready", 64'(arready), 64'(1));
        check("rst_bvalid",  64'(bvalid),  64'(0));
        check("rst_bresp",   64'(bresp),   64'(0));
        check("rst_rvalid",  64'(rvalid),  64'(0));
        check("rst_rlast",   64'(rlast),   64'(0));
        check("rst_rdata",   64'(rdata),   64'(0));
        check("rst_rresp",   64'(rresp),   64'(0));
        check("rst_pulse",   64'(wr_pulse_o), 64'(0));
        check_all_regs("rst_regs");

        // AW and W in the same cycle to index 3
        @(posedge aclk); #1;
        m_write(3, 32'hDEADBEEF, 4'hF, 1'b1);
        awaddr = 32'h0000_000C; awvalid = 1'b1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        check("t1_awready", 64'(awready), 64'(1));
        check("t1_wready",  64'(wready),  64'(1));
        @(posedge aclk); #1 awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        check("t1_bvalid_early", 64'(bvalid), 64'(0));
        @(negedge aclk);
        check("t1_bvalid", 64'(bvalid), 64'(1));
        check("t1_reg3",   64'(reg_o(3)), 64'(32'hDEADBEEF));
        check("t1_pulse",  64'(wr_pulse_o), 64'(12'h008));
        @(negedge aclk);
        check("t1_pulse_clear", 64'(wr_pulse_o), 64'(0));
        check("t1_bvalid_clear", 64'(bvalid), 64'(0));
        @(posedge aclk); #1;

        // W three cycles ahead of AW, index 1
        m_write(1, 32'h0102_0304, 4'hF, 1'b1);
        send_w(32'h0102_0304, 4'hF);
        @(negedge aclk);
        check("t2_wready_low", 64'(wready), 64'(0));
        check("t2_no_bvalid",  64'(bvalid), 64'(0));
        repeat (2) @(posedge aclk);
        #1;
        send_aw(mk_addr(1));
        @(negedge aclk);
        check("t2_bvalid_early", 64'(bvalid), 64'(0));
        @(negedge aclk);
        check("t2_bvalid", 64'(bvalid), 64'(1));
        check("t2_reg1",   64'(reg_o(1)), 64'(32'h0102_0304));
        drain();

        // Byte strobes
        do_write(2, 32'h1122_3344, 4'hF, 1'b1);
        drain();
        do_write(2, 32'hAABB_CCDD, 4'b0101, 1'b1);
        drain();
`ifdef AXI_LITE_REGFILE_STRB_EN
        check("strb_reg2", 64'(reg_o(2)), 64'(32'h11BB_33DD));
`else
        check("strb_reg2", 64'(reg_o(2)), 64'(32'hAABB_CCDD));
`endif

        // Error responses and read-only register
        do_write(NUM_REGS, 32'hFFFF_FFFF, 4'hF, 1'b1);
        drain();
        do_write(0, 32'h1234_5678, 4'hF, 1'b1);
        drain();
        check_all_regs("err_no_change");
        do_read(NUM_REGS);
        drain();
        do_read(15);
        drain();
        do_read(0);
        drain();

        // rready held low: read data stays stable
        rready = 1'b0;
        do_read(3);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("hold_rvalid",  64'(rvalid),  64'(1));
            check("hold_rdata",   64'(rdata),   64'(mreg[3]));
            check("hold_arready", 64'(arready), 64'(0));
        end
        @(posedge aclk); #1 rready = 1'b1;
        drain();

        // bready held low: second write accepted, executes on first B handshake
        bready = 1'b0;
        old6 = mreg[6];
        d5 = $urandom;
        d6 = ~old6;
        do_write(5, d5, 4'hF, 1'b0);
        do_write(6, d6, 4'hF, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            check("bhold_bvalid", 64'(bvalid), 64'(1));
            check("bhold_reg5",   64'(reg_o(5)), 64'(d5));
            check("bhold_reg6",   64'(reg_o(6)), 64'(old6));
        end
        @(posedge aclk); #1 bready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("b2b_bvalid", 64'(bvalid), 64'(1));
        check("b2b_reg6",   64'(reg_o(6)), 64'(d6));
        drain();

        // Read and write to the same register on the same edge
        old9 = mreg[9];
        new9 = ~old9;
        rq.push_back('{data: old9, resp: 2'b00});
        fork
            do_write(9, new9, 4'hF, 1'b1);
            begin
                @(posedge aclk); #1;
                send_ar(mk_addr(9));
            end
        join
        drain();
        check("same_edge_reg9", 64'(reg_o(9)), 64'(new9));

        // Reset between AW and W handshakes
        send_aw(mk_addr(4));
        @(negedge aclk); #2 areset = 1'b1;
        #1;
        check("mid_rst_awready", 64'(awready), 64'(1));
        check("mid_rst_bvalid",  64'(bvalid),  64'(0));
        check("mid_rst_pulse",   64'(wr_pulse_o), 64'(0));
        @(posedge aclk); #1 areset = 1'b0;
        bq.delete();
        rq.delete();
        for (int i = 0; i < NUM_REGS; i++) mreg[i] = RST_VAL;
        wd = $urandom;
        send_w(wd, 4'hF);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("mid_rst_no_bvalid", 64'(bvalid), 64'(0));
        end
        check("mid_rst_wready", 64'(wready), 64'(0));
        check_all_regs("mid_rst_regs");
        @(posedge aclk); #1;
        m_write(7, wd, 4'hF, 1'b1);
        send_aw(mk_addr(7));
        drain();
        check("mid_rst_reg7", 64'(reg_o(7)), 64'(wd));

        // Randomized traffic against the model
        for (int k = 0; k < 80; k++) begin
            int          idx;
            logic [3:0]  s;
            idx = int'($urandom_range(0, 15));
            s   = 4'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(idx, 32'($urandom), s, 1'b1);
            else                           do_read(idx);
            drain();
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < NUM_REGS; i++) status[i*DATA_W +: DATA_W] = $urandom;
            end
        end
        check_all_regs("final_regs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
